// File: rtl/rom_dl_packer.sv
// Packs HPS ROM download bytes into little-endian 16-bit SDRAM word writes and relocates the sprite region.
// States: IDLE empty | HAVE_LO low byte held | ISSUE DL_WR pulse | WAIT_BUSY/WAIT_DONE SDRAM handshake | FLUSH trailing byte
module rom_dl_packer #(
  parameter logic [7:0]  ROM_INDEX    = 8'd0,
  parameter logic [26:0] SPR_SRC_BASE = 27'h0100000,
  parameter logic [26:0] SPR_SIZE     = 27'h0200000,
  parameter logic [26:0] SPR_DST_BASE = 27'h0200000,
  parameter logic [3:0]  BUSY_TIMEOUT = 4'd15
) (
  input  logic        clk_sys,
  input  logic        nRESET,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic        ioctl_wait,
  input  logic        SDRAM_READY,
  output logic        DL_EN,
  output logic [15:0] DL_DATA,
  output logic [26:0] DL_ADDR,
  output logic        DL_WR
);

  typedef enum logic [2:0] {
    S_IDLE, S_HAVE_LO, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_FLUSH
  } state_t;

  localparam logic [26:0] SPR_END = SPR_SRC_BASE + SPR_SIZE;

  state_t      state_q;
  logic [7:0]  lo_q;
  logic [26:0] lo_addr_q;
  logic        pend_q;
  logic [7:0]  pend_data_q;
  logic [26:0] pend_addr_q;
  logic [3:0]  tmr_q;
  logic        en_q;
  logic        wr_q;
  logic [15:0] data_q;
  logic [26:0] addr_q;

  logic        sel;
  logic        accept;
  logic        done;
  logic        take;
  logic [26:0] take_addr;
  logic [7:0]  take_data;

  function automatic logic [26:0] remap(input logic [26:0] a);
    remap = (a >= SPR_SRC_BASE && a < SPR_END) ? (a - SPR_SRC_BASE + SPR_DST_BASE) : a;
  endfunction

  assign sel        = ioctl_download && (ioctl_index == ROM_INDEX);
  assign ioctl_wait = pend_q || (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY) ||
                      (state_q == S_WAIT_DONE) || (state_q == S_FLUSH);
  assign accept     = ioctl_wr && sel && !ioctl_wait;
  assign done       = (state_q == S_WAIT_DONE) && SDRAM_READY;

  // A held-back byte re-enters exactly as if it had just arrived in IDLE.
  always_comb begin
    take      = 1'b0;
    take_addr = ioctl_addr;
    take_data = ioctl_dout;
    if (state_q == S_IDLE) begin
      take = accept;
    end else if (done && pend_q) begin
      take      = 1'b1;
      take_addr = pend_addr_q;
      take_data = pend_data_q;
    end
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      lo_q        <= '0;
      lo_addr_q   <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_addr_q <= '0;
      tmr_q       <= '0;
      en_q        <= 1'b0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
    end else begin
      wr_q <= 1'b0;
      if (sel)                    en_q <= 1'b1;
      else if (state_q == S_IDLE) en_q <= 1'b0;

      if (take) begin
        pend_q <= 1'b0;
        if (!take_addr[0]) begin
          lo_q      <= take_data;
          lo_addr_q <= take_addr;
          state_q   <= S_HAVE_LO;
        end else begin
          data_q  <= {take_data, 8'h00};
          addr_q  <= remap({take_addr[26:1], 1'b0});
          wr_q    <= 1'b1;
          state_q <= S_ISSUE;
        end
      end else begin
        case (state_q)
          S_HAVE_LO: begin
            if (!sel) begin
              state_q <= S_FLUSH;
            end else if (accept) begin
              addr_q <= remap(lo_addr_q);
              if (ioctl_addr == (lo_addr_q | 27'd1)) begin
                data_q <= {ioctl_dout, lo_q};
              end else begin
                data_q      <= {8'h00, lo_q};
                pend_q      <= 1'b1;
                pend_data_q <= ioctl_dout;
                pend_addr_q <= ioctl_addr;
              end
              wr_q    <= 1'b1;
              state_q <= S_ISSUE;
            end
          end
          S_FLUSH: begin
            data_q  <= {8'h00, lo_q};
            addr_q  <= remap(lo_addr_q);
            wr_q    <= 1'b1;
            state_q <= S_ISSUE;
          end
          S_ISSUE: begin
            tmr_q   <= BUSY_TIMEOUT - 4'd1;
            state_q <= S_WAIT_BUSY;
          end
          S_WAIT_BUSY: begin
            if (!SDRAM_READY || tmr_q == 4'd0) state_q <= S_WAIT_DONE;
            else                               tmr_q   <= tmr_q - 4'd1;
          end
          S_WAIT_DONE: begin
            if (SDRAM_READY) state_q <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign DL_EN   = en_q;
  assign DL_DATA = data_q;
  assign DL_ADDR = addr_q;
  assign DL_WR   = wr_q;

endmodule

// File: tb/tb_rom_dl_packer.sv
// Bench for rom_dl_packer: directed cases plus random byte streams checked against a word-level scoreboard.
module tb_rom_dl_packer;

  localparam logic [26:0] SRC  = 27'h0100000;
  localparam logic [26:0] SIZE = 27'h0200000;
  localparam logic [26:0] DST  = 27'h0200000;

  logic        clk_sys = 1'b0;
  logic        nRESET = 1'b0;
  logic        ioctl_download, ioctl_wr, ioctl_wait, SDRAM_READY;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [26:0] ioctl_addr;
  logic        DL_EN, DL_WR;
  logic [15:0] DL_DATA;
  logic [26:0] DL_ADDR;

  int n_err = 0;
  int n_checks = 0;
  int n_wr = 0;
  int n_exp = 0;
  bit stuck_ready = 1'b0;
  bit prev_wr = 1'b0;

  logic [15:0] exp_d[$];
  logic [26:0] exp_a[$];
  bit          held = 1'b0;
  logic [26:0] held_a;
  logic [7:0]  held_d;

  rom_dl_packer dut (
    .clk_sys(clk_sys), .nRESET(nRESET), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait), .SDRAM_READY(SDRAM_READY),
    .DL_EN(DL_EN), .DL_DATA(DL_DATA), .DL_ADDR(DL_ADDR), .DL_WR(DL_WR)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] map_addr(input logic [26:0] a);
    logic [26:0] off;
    off = a - SRC;
    return (off < SIZE) ? off + DST : a;
  endfunction

  function automatic void emit(input logic [15:0] d, input logic [26:0] a);
    exp_d.push_back(d);
    exp_a.push_back(map_addr(a));
    n_exp++;
  endfunction

  // Word-level reference: pair an even byte with the byte at the next address, else write it alone.
  function automatic void model_byte(input logic [26:0] a, input logic [7:0] d);
    if (held) begin
      held = 1'b0;
      if (a == held_a + 27'd1) begin
        emit({d, held_d}, held_a);
        return;
      end
      emit({8'h00, held_d}, held_a);
    end
    if (!a[0]) begin
      held = 1'b1; held_a = a; held_d = d;
    end else begin
      emit({d, 8'h00}, {a[26:1], 1'b0});
    end
  endfunction

  function automatic void model_flush();
    if (held) emit({8'h00, held_d}, held_a);
    held = 1'b0;
  endfunction

  // SDRAM controller: drops READY a little after each write, or never when stuck.
  initial begin
    SDRAM_READY = 1'b1;
    forever begin
      @(negedge clk_sys);
      if (nRESET && DL_WR && !stuck_ready) begin
        repeat ($urandom_range(0, 3)) @(negedge clk_sys);
        SDRAM_READY = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk_sys);
        SDRAM_READY = 1'b1;
      end
    end
  end

  always @(negedge clk_sys) begin
    if (nRESET && DL_WR) begin
      n_wr++;
      if (prev_wr) chk("wr_one_cycle", 32'(DL_WR), 0);
      if (exp_d.size() == 0) begin
        chk("spurious_wr", 32'(DL_WR), 0);
      end else begin
        chk("dl_data", 32'(DL_DATA), 32'(exp_d.pop_front()));
        chk("dl_addr", 32'(DL_ADDR), 32'(exp_a.pop_front()));
        chk("dl_en_at_wr", 32'(DL_EN), 1);
      end
    end
    prev_wr = nRESET && DL_WR;
  end

  task automatic wait_idle();
    int n = 0;
    while (ioctl_wait && n < 200) begin @(negedge clk_sys); n++; end
    chk("wait_release", 32'(ioctl_wait), 0);
  endtask

  task automatic wait_en_low();
    int n = 0;
    while (DL_EN && n < 200) begin @(negedge clk_sys); n++; end
    chk("en_release", 32'(DL_EN), 0);
  endtask

  task automatic send_byte(input logic [26:0] a, input logic [7:0] d, input bit track);
    int n = 0;
    while (ioctl_wait && n < 200) begin @(negedge clk_sys); n++; end
    if (ioctl_wait) chk("strobe_wait_bound", 32'(ioctl_wait), 0);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    if (track) model_byte(a, d);
  endtask

  task automatic send_pair(input logic [26:0] a, input logic [7:0] lo, input logic [7:0] hi);
    send_byte(a, lo, 1'b1);
    send_byte(a + 27'd1, hi, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;
    logic [26:0] base;
    logic [26:0] a;
    int kind;
    ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_addr = '0;
    ioctl_dout = '0; ioctl_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_en", 32'(DL_EN), 0);
    chk("rst_data", 32'(DL_DATA), 0);
    chk("rst_addr", 32'(DL_ADDR), 0);
    chk("rst_wr", 32'(DL_WR), 0);
    nRESET = 1'b1;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("en_rise", 32'(DL_EN), 1);

    send_byte(27'h0, 8'h34, 1'b1);
    chk("lo_no_wait", 32'(ioctl_wait), 0);
    send_byte(27'h1, 8'h12, 1'b1);
    chk("pair_wr", 32'(DL_WR), 1);
    chk("pair_wait", 32'(ioctl_wait), 1);
    chk("pair_data", 32'(DL_DATA), 'h1234);
    chk("pair_addr", 32'(DL_ADDR), 0);
    @(negedge clk_sys);
    chk("wr_pulse_end", 32'(DL_WR), 0);
    wait_idle();
    chk("data_hold", 32'(DL_DATA), 'h1234);

    send_pair(27'h100000, 8'hCD, 8'hAB);
    chk("spr_data", 32'(DL_DATA), 'hABCD);
    chk("spr_addr", 32'(DL_ADDR), 'h200000);
    send_pair(27'h2FFFFE, 8'h01, 8'h02);
    chk("spr_top_addr", 32'(DL_ADDR), 'h3FFFFE);
    send_pair(27'h300000, 8'h03, 8'h04);
    chk("above_spr_addr", 32'(DL_ADDR), 'h300000);
    send_pair(27'h0FFFFE, 8'h05, 8'h06);
    chk("below_spr_addr", 32'(DL_ADDR), 'h0FFFFE);

    send_byte(27'h20, 8'hA1, 1'b1);
    send_byte(27'h41, 8'hB2, 1'b1);
    send_byte(27'h50, 8'hC3, 1'b1);
    send_byte(27'h60, 8'hD4, 1'b1);
    send_byte(27'h61, 8'hE5, 1'b1);
    send_byte(27'h71, 8'hF6, 1'b1);
    wait_idle();
    chk("odd_only_data", 32'(DL_DATA), 'hF600);
    chk("odd_only_addr", 32'(DL_ADDR), 'h70);

    stuck_ready = 1'b1;
    send_pair(27'h200, 8'h11, 8'h22);
    n = 0;
    while (ioctl_wait && n < 100) begin n++; @(negedge clk_sys); end
    chk("timeout_wait_cycles", 32'(n), 17);
    stuck_ready = 1'b0;

    send_byte(27'h10, 8'h5A, 1'b1);
    ioctl_download = 1'b0;
    model_flush();
    n = 0;
    while (!DL_WR && n < 50) begin @(negedge clk_sys); n++; end
    chk("flush_wr", 32'(DL_WR), 1);
    chk("flush_data", 32'(DL_DATA), 'h005A);
    chk("flush_addr", 32'(DL_ADDR), 'h10);
    n = 0;
    while (ioctl_wait && n < 50) begin @(negedge clk_sys); n++; end
    chk("flush_en_held", 32'(DL_EN), 1);
    @(negedge clk_sys);
    chk("flush_en_fall", 32'(DL_EN), 0);

    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    n0 = n_wr;
    for (int i = 0; i < 4; i++) begin
      send_byte(27'h400 + 27'(i), 8'(8'h90 + i), 1'b0);
      chk("other_idx_wait", 32'(ioctl_wait), 0);
      chk("other_idx_en", 32'(DL_EN), 0);
    end
    repeat (3) @(negedge clk_sys);
    chk("other_idx_no_wr", 32'(n_wr), 32'(n0));
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    @(negedge clk_sys);

    ioctl_download = 1'b1;
    @(negedge clk_sys);
    send_byte(27'h80, 8'h77, 1'b1);
    #2 nRESET = 1'b0;
    held = 1'b0;
    #1;
    chk("arst_wait", 32'(ioctl_wait), 0);
    chk("arst_en", 32'(DL_EN), 0);
    chk("arst_data", 32'(DL_DATA), 0);
    chk("arst_addr", 32'(DL_ADDR), 0);
    chk("arst_wr", 32'(DL_WR), 0);
    repeat (2) @(negedge clk_sys);
    nRESET = 1'b1;
    @(negedge clk_sys);
    send_pair(27'h90, 8'h11, 8'h22);
    chk("post_rst_data", 32'(DL_DATA), 'h2211);
    chk("post_rst_addr", 32'(DL_ADDR), 'h90);
    wait_idle();

    for (int g = 0; g < 50; g++) begin
      case ($urandom_range(0, 3))
        0:       base = 27'h0FFFF8;
        1:       base = 27'h2FFFF8;
        2:       base = 27'h000400;
        default: base = 27'($urandom & 32'h07FF_FFFE);
      endcase
      a = base + 27'(2 * $urandom_range(0, 7));
      stuck_ready = ($urandom_range(0, 9) == 0);
      kind = $urandom_range(0, 9);
      if (kind < 6)      send_pair(a, 8'($urandom), 8'($urandom));
      else if (kind < 8) send_byte(a, 8'($urandom), 1'b1);
      else               send_byte(a + 27'd1, 8'($urandom), 1'b1);
      stuck_ready = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        ioctl_download = 1'b0;
        model_flush();
        wait_en_low();
        ioctl_download = 1'b1;
        @(negedge clk_sys);
      end
    end

    ioctl_download = 1'b0;
    model_flush();
    wait_en_low();
    repeat (3) @(negedge clk_sys);
    chk("queue_drained", 32'(exp_d.size()), 0);
    chk("write_count", 32'(n_wr), 32'(n_exp));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
